// File: rtl/ch_est_pkg.sv
// Shared types, constants and select-code lookup for the NB-IoT channel-estimation control unit.
package ch_est_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MULT_STORE,
    ST_WR_LAST,
    ST_WAIT_SLOT,
    ST_INTERP
  } state_e;

  localparam int PILOTS_PER_SLOT = 4;
  localparam int NRS_ADDR_STEP   = 2;

  // Interpolation adder operand selects (s1a/s1b/s2a/s2b)
  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_HM   = 3'd1;  // averaged pilot H_m
  localparam logic [2:0] SEL_E    = 3'd2;  // one slope step
  localparam logic [2:0] SEL_2E   = 3'd3;  // two slope steps
  localparam logic [2:0] SEL_5E   = 3'd4;  // edge extrapolation term

  // Output mux selects (s_h1/s_h2)
  localparam logic [1:0] SEL_H_NONE = 2'd0;
  localparam logic [1:0] SEL_AVG    = 2'd1;  // averaged-estimate memory
  localparam logic [1:0] SEL_ADD1   = 2'd2;  // interior interpolation adder
  localparam logic [1:0] SEL_ADD2   = 2'd3;  // edge extrapolation adder

  typedef struct packed {
    logic [2:0] s1a;
    logic [2:0] s1b;
    logic [2:0] s2a;
    logic [2:0] s2b;
    logic [1:0] s_h1;
    logic [1:0] s_h2;
    logic       s_est;
  } sel_t;

  // Pilot comb offset within the PRB (v_shift mod 3)
  function automatic logic [1:0] base_offset(input logic [2:0] vs);
    return 2'(vs % 3'd3);
  endfunction

  // Index of the nearest pilot at or below subcarrier k, clamped to 0..3
  function automatic logic [1:0] nearest_pilot(input logic [3:0] k, input logic [1:0] v);
    logic [3:0] v4;
    logic [3:0] q;
    v4 = {2'b00, v};
    if (k < v4) return 2'd0;
    q = (k - v4) / 4'd3;
    return (q > 4'd3) ? 2'd3 : q[1:0];
  endfunction

  // Datapath select pattern for output subcarrier k with pilot offset v
  function automatic sel_t interp_sel(input logic [3:0] k, input logic [1:0] v);
    sel_t       s;
    logic [3:0] v4;
    logic [3:0] rel;
    logic [3:0] rem;
    s  = '0;
    v4 = {2'b00, v};
    if (k < v4 || k > v4 + 4'd9) begin
      s.s_est = 1'b1;
      s.s2a   = SEL_HM;
      s.s2b   = SEL_5E;
      s.s_h1  = SEL_ADD2;
      s.s_h2  = SEL_ADD2;
    end else begin
      rel = k - v4;
      rem = rel % 4'd3;
      if (rem == 4'd0) begin
        s.s_h1 = SEL_AVG;
        s.s_h2 = SEL_AVG;
      end else begin
        s.s_est = 1'b1;
        s.s1a   = SEL_HM;
        s.s1b   = (rem == 4'd1) ? SEL_E : SEL_2E;
        s.s_h1  = SEL_ADD1;
        s.s_h2  = SEL_ADD1;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/ch_est_interp_seq.sv
// Subcarrier counter and registered select lookup for the frequency-interpolation pass.
module ch_est_interp_seq
  import ch_est_pkg::*;
#(
  parameter int SEQ_LEN = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,     // pulses on the edge entering the setup cycle
  input  logic [2:0] v_shift_i,
  output logic [3:0] col_o,
  output logic       valid_o,
  output logic [1:0] addr_o,
  output sel_t       sel_o,
  output logic       last_o
);

  logic [1:0] v_q, v_d;
  logic       pend_q, pend_d;
  logic       run_q, run_d;
  logic [3:0] k_q, k_d;
  logic [1:0] addr_q, addr_d;
  sel_t       sel_q, sel_d;

  // Next counter value; output selects are precomputed so they register alongside k
  always_comb begin
    v_d    = v_q;
    pend_d = 1'b0;
    run_d  = run_q;
    k_d    = k_q;
    if (start_i) begin
      v_d    = base_offset(v_shift_i);
      pend_d = 1'b1;
    end
    if (pend_q) begin
      run_d = 1'b1;
      k_d   = 4'd0;
    end else if (run_q) begin
      if (k_q == 4'(SEQ_LEN - 1)) begin
        run_d = 1'b0;
        k_d   = 4'd0;
      end else begin
        k_d = k_q + 4'd1;
      end
    end
    sel_d  = run_d ? interp_sel(k_d, v_d) : '0;
    addr_d = run_d ? nearest_pilot(k_d, v_d) : 2'd0;
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= 2'd0;
      pend_q <= 1'b0;
      run_q  <= 1'b0;
      k_q    <= 4'd0;
      addr_q <= 2'd0;
      sel_q  <= '0;
    end else begin
      v_q    <= v_d;
      pend_q <= pend_d;
      run_q  <= run_d;
      k_q    <= k_d;
      addr_q <= addr_d;
      sel_q  <= sel_d;
    end
  end

  assign col_o   = k_q;
  assign valid_o = run_q;
  assign addr_o  = addr_q;
  assign sel_o   = sel_q;
  assign last_o  = run_q && (k_q == 4'(SEQ_LEN - 1));

endmodule

// File: rtl/ch_est_control_unit.sv
// Channel-estimation control: NRS multiply/average bursts per slot, then interpolation hand-off.
module ch_est_control_unit
  import ch_est_pkg::*;
#(
  parameter int NRS_ADDR           = 4,
  parameter int OUT_SEL_SEQ_LENGTH = 12,
  parameter int NRS_DELAY_CLK      = 1600
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                demap_ready,
  input  logic                NRS_gen_ready,
  input  logic [2:0]          v_shift,
  output logic [3:0]          col,
  output logic [1:0]          nrs_index_addr,
  output logic                demap_read,
  output logic [NRS_ADDR-1:0] rd_addr_nrs,
  output logic                valid_eqlz,
  output logic [1:0]          addr_mem,
  output logic                mult_mem_en,
  output logic                avg_mem_en,
  output logic                en_reg_E,
  output logic                en_reg_2E,
  output logic                en_reg_5E,
  output logic [2:0]          s1a,
  output logic [2:0]          s1b,
  output logic [2:0]          s2a,
  output logic [2:0]          s2b,
  output logic [1:0]          s_h1,
  output logic [1:0]          s_h2,
  output logic                s_est
);

  // A burst plus write-back must fit inside one slot spacing; a nonsensical period disables triggering
  localparam bit SPACING_OK = (NRS_DELAY_CLK / 4) > (PILOTS_PER_SLOT + 1);
  localparam logic [1:0] LAST_PILOT = 2'(PILOTS_PER_SLOT - 1);

  state_e              state_q, state_d;
  logic [1:0]          j_q, j_d;
  logic                slot2_q, slot2_d;
  logic [NRS_ADDR-1:0] rd_addr_q, rd_addr_d;

  logic       demap_read_q, demap_read_d;
  logic [1:0] burst_addr_q, burst_addr_d;
  logic       mult_en_q, mult_en_d;
  logic       avg_en_q, avg_en_d;
  logic       slope_en_q, slope_en_d;
  logic       wr_en;

  logic       trigger;
  logic       interp_start;
  logic       interp_last;
  logic [1:0] interp_addr;
  sel_t       sel;

  assign trigger      = demap_ready && NRS_gen_ready && SPACING_OK;
  assign interp_start = (state_q == ST_WR_LAST) && slot2_q;

  // State, burst counter, slot flag and free-running NRS read address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      j_q       <= 2'd0;
      slot2_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      slot2_q   <= slot2_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    slot2_d   = slot2_q;
    rd_addr_d = (state_q == ST_MULT_STORE) ? rd_addr_q + NRS_ADDR'(NRS_ADDR_STEP) : rd_addr_q;
    case (state_q)
      ST_IDLE, ST_WAIT_SLOT: begin
        if (trigger) begin
          state_d = ST_MULT_STORE;
          j_d     = 2'd0;
        end
      end
      ST_MULT_STORE: begin
        if (j_q == LAST_PILOT) state_d = ST_WR_LAST;
        else                   j_d     = j_q + 2'd1;
      end
      ST_WR_LAST: begin
        slot2_d = ~slot2_q;
        state_d = slot2_q ? ST_INTERP : ST_WAIT_SLOT;
      end
      ST_INTERP: begin
        slot2_d = 1'b0;
        if (interp_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state; write enable trails the read by one stage
  always_comb begin
    demap_read_d = (state_d == ST_MULT_STORE);
    burst_addr_d = (state_d == ST_MULT_STORE) ? j_d :
                   (state_d == ST_WR_LAST)    ? LAST_PILOT : 2'd0;
    wr_en        = ((state_d == ST_MULT_STORE) && (j_d != 2'd0)) || (state_d == ST_WR_LAST);
    mult_en_d    = wr_en && !slot2_q;
    avg_en_d     = wr_en && slot2_q;
    slope_en_d   = (state_d == ST_INTERP) && (state_q == ST_WR_LAST);
  end

  // Registered Moore outputs for the burst phase and slope-register setup
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      demap_read_q <= 1'b0;
      burst_addr_q <= 2'd0;
      mult_en_q    <= 1'b0;
      avg_en_q     <= 1'b0;
      slope_en_q   <= 1'b0;
    end else begin
      demap_read_q <= demap_read_d;
      burst_addr_q <= burst_addr_d;
      mult_en_q    <= mult_en_d;
      avg_en_q     <= avg_en_d;
      slope_en_q   <= slope_en_d;
    end
  end

  ch_est_interp_seq #(
    .SEQ_LEN (OUT_SEL_SEQ_LENGTH)
  ) u_interp_seq (
    .clk       (clk),
    .rst_n     (rst),
    .start_i   (interp_start),
    .v_shift_i (v_shift),
    .col_o     (col),
    .valid_o   (valid_eqlz),
    .addr_o    (interp_addr),
    .sel_o     (sel),
    .last_o    (interp_last)
  );

  // Burst and interpolation address registers are never non-zero at the same time
  assign addr_mem       = burst_addr_q | interp_addr;
  assign nrs_index_addr = burst_addr_q;
  assign demap_read     = demap_read_q;
  assign rd_addr_nrs    = rd_addr_q;
  assign mult_mem_en    = mult_en_q;
  assign avg_mem_en     = avg_en_q;
  assign en_reg_E       = slope_en_q;
  assign en_reg_2E      = slope_en_q;
  assign en_reg_5E      = slope_en_q;
  assign s1a            = sel.s1a;
  assign s1b            = sel.s1b;
  assign s2a            = sel.s2a;
  assign s2b            = sel.s2b;
  assign s_h1           = sel.s_h1;
  assign s_h2           = sel.s_h2;
  assign s_est          = sel.s_est;

endmodule

// File: tb/tb_ch_est_control_unit.sv
// Scoreboard bench for ch_est_control_unit: stimulus pushes time-stamped expected outputs, a monitor checks every cycle.
module tb_ch_est_control_unit;
  import ch_est_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       demap_ready = 1'b0;
  logic       NRS_gen_ready = 1'b0;
  logic [2:0] v_shift = 3'd0;

  logic [3:0] col;
  logic [1:0] nrs_index_addr;
  logic       demap_read;
  logic [3:0] rd_addr_nrs;
  logic       valid_eqlz;
  logic [1:0] addr_mem;
  logic       mult_mem_en, avg_mem_en;
  logic       en_reg_E, en_reg_2E, en_reg_5E;
  logic [2:0] s1a, s1b, s2a, s2b;
  logic [1:0] s_h1, s_h2;
  logic       s_est;

  ch_est_control_unit #(
    .NRS_ADDR (4), .OUT_SEL_SEQ_LENGTH (12), .NRS_DELAY_CLK (1600)
  ) dut (
    .clk (clk), .rst (rst), .demap_ready (demap_ready), .NRS_gen_ready (NRS_gen_ready),
    .v_shift (v_shift), .col (col), .nrs_index_addr (nrs_index_addr), .demap_read (demap_read),
    .rd_addr_nrs (rd_addr_nrs), .valid_eqlz (valid_eqlz), .addr_mem (addr_mem),
    .mult_mem_en (mult_mem_en), .avg_mem_en (avg_mem_en), .en_reg_E (en_reg_E),
    .en_reg_2E (en_reg_2E), .en_reg_5E (en_reg_5E), .s1a (s1a), .s1b (s1b), .s2a (s2a),
    .s2b (s2b), .s_h1 (s_h1), .s_h2 (s_h2), .s_est (s_est)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] col;
    logic [1:0] nrs;
    logic       dr;
    logic [3:0] rd;
    logic       val;
    logic [1:0] addr;
    logic       mult, avg, e1, e2, e5;
    logic [2:0] s1a, s1b, s2a, s2b;
    logic [1:0] sh1, sh2;
    logic       sest;
  } ovec_t;

  typedef struct {
    int    cyc;
    ovec_t v;
  } exp_t;

  exp_t       q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [3:0] rd_model = 4'd0;   // NRS address the next burst starts from
  logic [3:0] rd_hold = 4'd0;    // value rd_addr_nrs shows while no burst runs

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ovec_t sample();
    ovec_t o;
    o = {col, nrs_index_addr, demap_read, rd_addr_nrs, valid_eqlz, addr_mem, mult_mem_en,
         avg_mem_en, en_reg_E, en_reg_2E, en_reg_5E, s1a, s1b, s2a, s2b, s_h1, s_h2, s_est};
    return o;
  endfunction

  // Reference for one interpolation output: pilots sit at v, v+3, v+6, v+9
  task automatic model_interp(input int k, input int v, inout ovec_t o);
    int pil[4];
    int hit;
    for (int m = 0; m < 4; m++) pil[m] = v + 3 * m;
    hit = -1;
    for (int m = 0; m < 4; m++) if (pil[m] == k) hit = m;
    if (hit >= 0) begin
      o.addr = 2'(hit); o.sh1 = SEL_AVG; o.sh2 = SEL_AVG; o.sest = 1'b0;
    end else if (k < pil[0] || k > pil[3]) begin
      o.addr = (k < pil[0]) ? 2'd0 : 2'd3;
      o.sest = 1'b1; o.s2a = SEL_HM; o.s2b = SEL_5E; o.sh1 = SEL_ADD2; o.sh2 = SEL_ADD2;
    end else begin
      for (int m = 0; m < 3; m++) begin
        if (k > pil[m] && k < pil[m + 1]) begin
          o.addr = 2'(m); o.sest = 1'b1; o.s1a = SEL_HM;
          o.s1b  = (k - pil[m] == 1) ? SEL_E : SEL_2E;
          o.sh1  = SEL_ADD1; o.sh2 = SEL_ADD1;
        end
      end
    end
  endtask

  // Expected activity for a burst whose first cycle is t
  task automatic push_burst(input int t, input int slot, input logic [3:0] base, input logic [2:0] vs);
    exp_t e;
    int   v;
    logic [3:0] after;
    after = base + 4'd8;
    for (int j = 0; j < 5; j++) begin
      e.cyc = t + j;
      e.v = '0;
      e.v.dr   = (j < 4);
      e.v.addr = (j < 4) ? 2'(j) : 2'd3;
      e.v.nrs  = e.v.addr;
      e.v.rd   = (j < 4) ? base + 4'(2 * j) : after;
      if (j > 0) begin
        if (slot == 1) e.v.mult = 1'b1;
        else           e.v.avg  = 1'b1;
      end
      q.push_back(e);
    end
    if (slot == 2) begin
      e.cyc = t + 5; e.v = '0; e.v.rd = after;
      e.v.e1 = 1'b1; e.v.e2 = 1'b1; e.v.e5 = 1'b1;
      q.push_back(e);
      v = int'(vs) % 3;
      for (int k = 0; k < 12; k++) begin
        e.cyc = t + 6 + k; e.v = '0; e.v.rd = after;
        e.v.val = 1'b1; e.v.col = 4'(k);
        model_interp(k, v, e.v);
        q.push_back(e);
      end
    end
  endtask

  // Monitor: active cycles pop the scoreboard, quiet cycles must show the reset-like vector
  always @(negedge clk) begin : monitor
    ovec_t got;
    ovec_t idle;
    exp_t  e;
    logic  act;
    got  = sample();
    act  = demap_read | mult_mem_en | avg_mem_en | en_reg_E | en_reg_2E | en_reg_5E | valid_eqlz;
    idle = '0;
    idle.rd = rd_hold;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_vec++; n_bad++;
      $display("FAIL missing_output cyc=%0d expected_at=%0d got=%h required=%h", cyc, e.cyc, got, e.v);
    end
    if (act) begin
      n_vec++;
      if (q.size() == 0 || q[0].cyc != cyc) begin
        n_bad++;
        $display("FAIL unexpected_output cyc=%0d got=%h", cyc, got);
      end else begin
        e = q.pop_front();
        if (got !== e.v) begin
          n_bad++;
          $display("FAIL active_vector cyc=%0d got=%h required=%h", cyc, got, e.v);
        end
      end
    end else if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      n_vec++; n_bad++;
      $display("FAIL missing_output cyc=%0d got=%h required=%h", cyc, got, e.v);
    end else begin
      n_vec++;
      if (got !== idle) begin
        n_bad++;
        $display("FAIL idle_vector cyc=%0d got=%h required=%h", cyc, got, idle);
      end
    end
  end

  // Trigger one slot burst and follow it until the unit is quiet again
  task automatic do_slot(input int slot, input logic [2:0] vs);
    int t;
    @(negedge clk);
    v_shift = vs; demap_ready = 1'b1; NRS_gen_ready = 1'b1;
    t = cyc + 1;
    push_burst(t, slot, rd_model, vs);
    $display("burst slot=%0d v_shift=%0d rd_base=%0d start_cycle=%0d", slot, vs, rd_model, t);
    @(negedge clk); NRS_gen_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); demap_ready = 1'b0;
    rd_model = rd_model + 4'd8;
    rd_hold  = rd_model;
    if (slot == 2) begin
      while (cyc < t + 8) @(negedge clk);
      v_shift = 3'($urandom_range(0, 5));
      while (cyc < t + 19) @(negedge clk);
    end else begin
      while (cyc < t + 6) @(negedge clk);
    end
  endtask

  task automatic full_pass(input logic [2:0] vs, input int gap);
    do_slot(1, vs);
    repeat (gap) @(negedge clk);
    do_slot(2, vs);
  endtask

  initial begin : stim
    int         t;
    ovec_t      got;
    logic [2:0] vs;
    rst = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int s = 0; s < 6; s++) begin
        @(negedge clk);
        demap_ready   = (c == 2);
        NRS_gen_ready = (c == 1);
        v_shift       = 3'(s);
        repeat (100) @(negedge clk);
      end
    end
    demap_ready = 1'b0; NRS_gen_ready = 1'b0;

    full_pass(3'd0, 396);
    repeat (20) @(negedge clk);
    full_pass(3'd5, 396);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(5, 40)) @(negedge clk);
      vs = 3'($urandom_range(0, 5));
      full_pass(vs, $urandom_range(394, 420));
    end

    // Abort a burst at its third cycle
    repeat (30) @(negedge clk);
    vs = 3'($urandom_range(0, 5));
    v_shift = vs; demap_ready = 1'b1; NRS_gen_ready = 1'b1;
    t = cyc + 1;
    push_burst(t, 1, rd_model, vs);
    $display("burst slot=1 v_shift=%0d rd_base=%0d start_cycle=%0d (reset at j=2)", vs, rd_model, t);
    @(negedge clk); NRS_gen_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    q.delete();
    rd_model = 4'd0; rd_hold = 4'd0; demap_ready = 1'b0;
    #1;
    got = sample();
    n_vec++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL reset_abort got=%h required=0", got);
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    full_pass(3'd3, 396);
    repeat (30) @(negedge clk);

    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d pending required=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
